// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: fetch/decode/execute sequencer for the accumulator CPU; define ILLEGAL_TRAP_EN to halt on opcodes 9-E
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] ir_in,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       mar_sel_pc,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_load,
  output logic       flag_load,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       halted,
  output logic       bus_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);
  typedef enum logic [2:0] {IDLE, FADDR, FRD, DEC, MEM, HALT} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic bus_err_q;
  logic [3:0] op;
  logic on, waiting, timeout, mem_op, rd_op, trap;
  logic unused_operand;
  assign op = ir_in[7:4];
  assign unused_operand = ^ir_in[3:0];
  assign on = !reset;
  assign waiting = state_q == FRD || state_q == MEM;
  assign timeout = waiting && !mem_ready && cnt_q == 8'(MEM_TIMEOUT - 1);
  assign mem_op = op >= 4'h1 && op <= 4'h4;
  assign rd_op = op == 4'h1 || op == 4'h3 || op == 4'h4;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap = op >= 4'h9 && op <= 4'hE;
  always_ff @(posedge clk) illegal_q <= reset ? 1'b0 : illegal_q | (state_q == DEC && trap);
  assign illegal_op = on && illegal_q;
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? FADDR : IDLE;
      FADDR:   state_d = FRD;
      FRD:     state_d = mem_ready ? DEC : timeout ? HALT : FRD;
      DEC:     state_d = (op == 4'hF || trap) ? HALT : mem_op ? MEM : FADDR;
      MEM:     state_d = mem_ready ? FADDR : timeout ? HALT : MEM;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    cnt_d = (waiting && state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_q | timeout;
    end
  end
  assign ir_load    = on && state_q == FRD && mem_ready;
  assign pc_inc     = ir_load;
  assign pc_load    = on && state_q == DEC && (op == 4'h5 || (op == 4'h6 && zero_flag) || (op == 4'h7 && carry_flag));
  assign mar_sel_pc = on && state_q == FADDR;
  assign mar_load   = mar_sel_pc || (on && state_q == DEC && mem_op);
  assign mem_rd     = on && (state_q == FRD || (state_q == MEM && op != 4'h2));
  assign mem_wr     = on && state_q == MEM && op == 4'h2;
  assign acc_load   = on && ((state_q == DEC && op == 4'h8) || (state_q == MEM && mem_ready && rd_op));
  assign flag_load  = on && state_q == MEM && mem_ready && (op == 4'h3 || op == 4'h4);
  assign alu_op     = !acc_load ? 2'b00 : state_q == DEC ? 2'b11 : op == 4'h3 ? 2'b01 : op == 4'h4 ? 2'b10 : 2'b00;
  assign busy       = on && state_q != IDLE && state_q != HALT;
  assign halted     = on && state_q == HALT;
  assign bus_err    = on && bus_err_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: random instruction stream scored per instruction window, plus directed timeout/reset/halt cases
module tb_cpu_ctrl_fsm;
  localparam int N_RAND = 60;
  typedef struct {
    logic [3:0] op;
    logic [3:0] arg;
    int wf;
    int wm;
    bit z;
    bit c;
  } ins_t;
  typedef struct {
    int op, cyc, rd, wr, mar, sel, irl, pci, pcl, accl, alu, fl, both, bsy, albad;
  } rec_t;
  logic clk, reset, run, zero_flag, carry_flag, mem_ready;
  logic [7:0] ir_in;
  logic ir_load, pc_inc, pc_load, mar_load, mar_sel_pc, mem_rd, mem_wr, acc_load, flag_load, busy, halted, bus_err;
  logic [1:0] alu_op;
  logic [14:0] outs;
`ifdef ILLEGAL_TRAP_EN
  logic illegal_op;
`endif
  int n_cmp = 0, n_err = 0;
  rec_t sb[$];
  ins_t fq[$];
  ins_t cur;
  rec_t o;
  bit drv_en = 0, mon_en = 0, done = 0, open = 0, fetch = 0;
  int cnt = 0, issued = 0, waits;
  cpu_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_in(ir_in), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .mem_ready(mem_ready), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .mar_sel_pc(mar_sel_pc), .mem_rd(mem_rd), .mem_wr(mem_wr), .acc_load(acc_load), .flag_load(flag_load),
    .alu_op(alu_op), .busy(busy), .halted(halted), .bus_err(bus_err)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );
  assign outs = {ir_load, pc_inc, pc_load, mar_load, mar_sel_pc, mem_rd, mem_wr, acc_load, flag_load, alu_op, busy, halted, bus_err, 1'b0};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, got no finish, want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  function automatic ins_t mk(int op, int arg, int wf, int wm, bit z, bit c);
    ins_t i;
    i.op = 4'(op);
    i.arg = 4'(arg);
    i.wf = wf;
    i.wm = wm;
    i.z = z;
    i.c = c;
    return i;
  endfunction
  function automatic ins_t rand_ins();
`ifdef ILLEGAL_TRAP_EN
    return mk($urandom_range(0, 8), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
    return mk($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`endif
  endfunction
  function automatic rec_t model(ins_t i);
    rec_t e;
    int mw;
    e = '{default: 0};
    mw = (i.op >= 1 && i.op <= 4) ? i.wm + 1 : 0;
    e.op = int'(i.op);
    e.cyc = 3 + i.wf + mw;
    e.rd = i.wf + 1 + (i.op == 2 ? 0 : mw);
    e.wr = i.op == 2 ? mw : 0;
    e.mar = mw != 0 ? 2 : 1;
    e.sel = 1;
    e.irl = 1;
    e.pci = 1;
    e.pcl = int'(i.op == 5 || (i.op == 6 && i.z) || (i.op == 7 && i.c));
    e.accl = int'(i.op == 1 || i.op == 3 || i.op == 4 || i.op == 8);
    e.alu = i.op == 8 ? 3 : i.op == 3 ? 1 : i.op == 4 ? 2 : 0;
    e.fl = int'(i.op == 3 || i.op == 4);
    e.bsy = e.cyc;
    return e;
  endfunction
  task automatic close_window();
    rec_t e;
    string p;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    p = $sformatf("op%0h_", e.op);
    chk({p, "cycles"}, o.cyc, e.cyc);
    chk({p, "mem_rd_cycles"}, o.rd, e.rd);
    chk({p, "mem_wr_cycles"}, o.wr, e.wr);
    chk({p, "mar_load"}, o.mar, e.mar);
    chk({p, "mar_sel_pc"}, o.sel, e.sel);
    chk({p, "ir_load"}, o.irl, e.irl);
    chk({p, "pc_inc"}, o.pci, e.pci);
    chk({p, "pc_load"}, o.pcl, e.pcl);
    chk({p, "acc_load"}, o.accl, e.accl);
    chk({p, "alu_op"}, o.alu, e.alu);
    chk({p, "flag_load"}, o.fl, e.fl);
    chk({p, "rd_wr_overlap"}, o.both, e.both);
    chk({p, "busy_cycles"}, o.bsy, e.bsy);
    chk({p, "alu_op_without_load"}, o.albad, e.albad);
  endtask
  initial forever begin
    @(negedge clk);
    if (drv_en) begin
      if (mar_load && mar_sel_pc) begin
        if (fq.size() != 0) cur = fq.pop_front();
        else if (issued < N_RAND) begin
          cur = rand_ins();
          issued++;
        end else cur = mk(15, 0, $urandom_range(0, 3), 0, 0, 0);
        sb.push_back(model(cur));
        fetch = 1;
        cnt = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end else if (mem_rd || mem_wr) begin
        mem_ready = cnt == (fetch ? cur.wf : cur.wm);
        if (mem_ready) begin
          if (fetch) begin
            ir_in = {cur.op, cur.arg};
            zero_flag = cur.z;
            carry_flag = cur.c;
          end
          fetch = 0;
          cnt = 0;
        end else cnt++;
      end else mem_ready = 1'($urandom_range(0, 1));
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (mon_en && !done) begin
      if (open && (halted || (mar_load && mar_sel_pc))) begin
        close_window();
        open = 0;
        if (halted) done = 1;
      end
      if (mar_load && mar_sel_pc && !done) begin
        open = 1;
        o = '{default: 0};
      end
      if (open) begin
        o.cyc++;
        o.rd += int'(mem_rd);
        o.wr += int'(mem_wr);
        o.mar += int'(mar_load);
        o.sel += int'(mar_sel_pc);
        o.irl += int'(ir_load);
        o.pci += int'(pc_inc);
        o.pcl += int'(pc_load);
        o.accl += int'(acc_load);
        if (acc_load) o.alu = int'(alu_op);
        o.fl += int'(flag_load);
        o.both += int'(mem_rd && mem_wr);
        o.bsy += int'(busy);
        o.albad += int'(!acc_load && alu_op != 2'b00);
      end
    end
  end
  task automatic do_reset();
    reset = 1;
    run = 0;
    mem_ready = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic run_until_halt();
    run = 1;
    mem_ready = 1;
    waits = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      run = 0;
      #1;
      waits++;
      if (halted) break;
    end
  endtask
  initial begin
    reset = 1;
    run = 1;
    mem_ready = 1;
    ir_in = 8'h35;
    zero_flag = 1;
    carry_flag = 1;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs_forced", int'(outs), 0);
    reset = 0;
    run = 0;
    @(negedge clk);
    #1 chk("idle_outputs", int'(outs), 0);
    fq.push_back(mk(0, 0, 0, 0, 0, 0));
    fq.push_back(mk(0, 0, 0, 0, 0, 0));
    fq.push_back(mk(3, 5, 0, 1, 0, 0));
    fq.push_back(mk(6, 10, 0, 0, 0, 0));
    fq.push_back(mk(6, 10, 0, 0, 1, 0));
    fq.push_back(mk(2, 7, 3, 3, 0, 0));
    fq.push_back(mk(8, 3, 1, 0, 0, 0));
    fq.push_back(mk(7, 1, 0, 0, 0, 1));
`ifndef ILLEGAL_TRAP_EN
    fq.push_back(mk(9, 12, 0, 0, 0, 0));
`endif
    drv_en = 1;
    mon_en = 1;
    run = 1;
    @(negedge clk);
    run = 0;
    for (int k = 0; k < 5000; k++) begin
      if (done) break;
      @(negedge clk);
    end
    #2;
    chk("random_phase_reached_halt", int'(done), 1);
    chk("scoreboard_left", sb.size(), 0);
    chk("random_halted", int'(halted), 1);
    chk("random_busy", int'(busy), 0);
    chk("random_bus_err", int'(bus_err), 0);
    run = 1;
    repeat (3) @(negedge clk);
    #1 chk("halt_ignores_run", int'({halted, busy}), 2);
    drv_en = 0;
    mon_en = 0;
    @(negedge clk);
    do_reset();
    run = 1;
    mem_ready = 0;
    @(negedge clk);
    run = 0;
    #1 chk("timeout_faddr", int'(mar_sel_pc), 1);
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (halted) break;
      waits += int'(mem_rd);
    end
    chk("timeout_wait_cycles", waits, 4);
    chk("timeout_bus_err", int'(bus_err), 1);
    chk("timeout_halted", int'(halted), 1);
    run = 1;
    repeat (3) @(negedge clk);
    #1 chk("timeout_run_ignored", int'({halted, bus_err}), 3);
    do_reset();
    #1 chk("reset_clears_bus_err", int'({bus_err, halted, busy}), 0);
    run = 1;
    mem_ready = 1;
    @(negedge clk);
    run = 0;
    @(negedge clk);
    #1 chk("sta_fetch_ir_load", int'(ir_load), 1);
    ir_in = 8'h23;
    @(negedge clk);
    mem_ready = 0;
    #1 chk("sta_dec_mar_operand", int'({mar_load, mar_sel_pc}), 2);
    @(negedge clk);
    #1 chk("sta_mem_wr", int'({mem_wr, mem_rd}), 2);
    reset = 1;
    mem_ready = 1;
    #1 chk("sta_reset_drops_wr", int'(mem_wr), 0);
    @(negedge clk);
    reset = 0;
    mem_ready = 0;
    #1 chk("sta_reset_to_idle", int'({busy, halted}), 0);
    ir_in = 8'hF0;
    run_until_halt();
    chk("hlt_cycles", waits, 4);
    chk("hlt_halted", int'({halted, busy}), 2);
`ifdef ILLEGAL_TRAP_EN
    do_reset();
    #1 chk("trap_reset_clear", int'(illegal_op), 0);
    ir_in = 8'h9C;
    run_until_halt();
    chk("trap_cycles", waits, 4);
    chk("trap_illegal_op", int'(illegal_op), 1);
    chk("trap_bus_err", int'(bus_err), 0);
    do_reset();
    #1 chk("trap_cleared", int'(illegal_op), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
